pdm_repeater: RTL

Parametrised successor to the fixed-rate microphone-to-amplifier passthrough. It generates the PDM microphone clock from the 100 MHz system clock with a parametrised divider, samples the selected microphone channel, and drives the PWM amplifier in one of three modes: muted, passthrough, or a programmable delay. In delay mode, the PDM bit stream is packed into words and played back through a circular block-RAM buffer. It sits between the board microphone pins and the mono audio amplifier pins, and runs entirely in the `clk_100mhz` domain.

---
 rtl/pdm_repeater.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pdm_repeater.sv
// PDM microphone-to-amplifier repeater: generates m_clk, samples the selected channel and
// drives the amplifier muted, in passthrough, or through a word-packed circular delay buffer.
module pdm_repeater #(
  parameter int unsigned CLK_DIV = 40,
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned ADDR_W  = 10
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              m_data,
  output logic              m_clk,
  output logic              lrsel,
  input  logic              chan_sel,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] delay_words,
  output logic              ampPWM,
  output logic              ampsd,
  output logic              buf_ready
);

  localparam int unsigned HALF   = CLK_DIV / 2;
  localparam int unsigned DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BC_W   = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam int unsigned FILL_W = ADDR_W + 1;

  localparam logic [1:0] MODE_PASS  = 2'b01;
  localparam logic [1:0] MODE_DELAY = 2'b10;

  logic [DIV_W-1:0]  r_div;
  logic              r_m_clk;
  logic              r_chan;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_dly;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [WORD_W-1:0] r_in;
  logic [WORD_W-1:0] r_out;
  logic              r_load;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [FILL_W-1:0] r_fill;
  logic              r_buf_ready;
  logic              r_amp;
  logic              r_ampsd;
  logic [WORD_W-1:0] r_rd_data;
  logic [WORD_W-1:0] r_ram [DEPTH];

  logic              w_strobe;
  logic              w_restart;
  logic              w_active;
  logic              w_boundary;
  logic [ADDR_W-1:0] w_d;
  logic [FILL_W-1:0] w_dp1;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [WORD_W-1:0] w_word;

  // Sample point sits at the end of the phase in which the selected mic drives data.
  assign w_strobe   = r_chan ? (r_div == DIV_W'(HALF - 1)) : (r_div == DIV_W'(CLK_DIV - 1));
  assign w_restart  = (mode != r_mode) || (delay_words != r_dly) || (chan_sel != r_chan);
  assign w_active   = (r_mode == MODE_DELAY) && !w_restart;
  assign w_boundary = w_active && w_strobe && (r_bit_cnt == BC_W'(WORD_W - 1));
  assign w_d        = (r_dly == '0) ? ADDR_W'(1) : r_dly;
  assign w_dp1      = {1'b0, w_d} + FILL_W'(1);
  assign w_rd_addr  = r_wr_ptr - w_d;
  assign w_word     = {r_in[WORD_W-2:0], m_data};

  always_comb begin
    w_fill_nxt = r_fill;
    if (w_boundary && (r_fill != w_dp1)) begin
      w_fill_nxt = r_fill + FILL_W'(1);
    end
  end

  // Clock divider, input capture registers and amplifier outputs.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      r_div   <= '0;
      r_m_clk <= 1'b0;
      r_chan  <= 1'b0;
      r_mode  <= 2'b00;
      r_dly   <= '0;
      r_amp   <= 1'b0;
      r_ampsd <= 1'b0;
    end else begin
      r_div   <= (r_div == DIV_W'(CLK_DIV - 1)) ? '0 : r_div + DIV_W'(1);
      r_m_clk <= (r_div < DIV_W'(HALF));
      r_chan  <= chan_sel;
      r_mode  <= mode;
      r_dly   <= delay_words;
      r_ampsd <= (mode == MODE_PASS) || (mode == MODE_DELAY);
      case (mode)
        MODE_PASS: begin
          if (w_strobe) r_amp <= m_data;
        end
        MODE_DELAY: begin
          if (!w_active || !r_buf_ready) r_amp <= 1'b0;
          else if (w_strobe)             r_amp <= r_out[WORD_W-1];
        end
        default: r_amp <= 1'b0;
      endcase
    end
  end

  // Delay datapath; anything other than steady delay mode holds it in restart.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_in        <= '0;
      r_out       <= '0;
      r_load      <= 1'b0;
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_buf_ready <= 1'b0;
    end else if (!w_active) begin
      r_bit_cnt   <= '0;
      r_in        <= '0;
      r_out       <= '0;
      r_load      <= 1'b0;
      r_fill      <= '0;
      r_buf_ready <= 1'b0;
    end else begin
      r_load      <= w_boundary;
      r_fill      <= w_fill_nxt;
      r_buf_ready <= (w_fill_nxt == w_dp1);
      if (w_strobe) begin
        r_in      <= w_word;
        r_bit_cnt <= w_boundary ? '0 : r_bit_cnt + BC_W'(1);
      end
      if (r_load)        r_out <= r_rd_data;
      else if (w_strobe) r_out <= {r_out[WORD_W-2:0], 1'b0};
      if (w_boundary)    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
    end
  end

  // Buffer RAM; the read address never equals the write address since D >= 1.
  always_ff @(posedge clk_100mhz) begin
    if (w_boundary) begin
      r_ram[r_wr_ptr] <= w_word;
      r_rd_data       <= r_ram[w_rd_addr];
    end
  end

  assign m_clk     = r_m_clk;
  assign lrsel     = r_chan;
  assign ampPWM    = r_amp;
  assign ampsd     = r_ampsd;
  assign buf_ready = r_buf_ready;

endmodule
